rmt_demo: RTL and testbench
===========================

// Module: rmt_demo
// PURPOSE
//  AXI4-Stream register slice at the front of the RMT extract pipeline. Carries packets
//  unmodified from s_axis to m_axis: 1-cycle latency, full throughput, registered s_axis_tready.
//  The first-beat tuser is latched and driven on every output beat of that packet.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH    32            AXI-Lite data width; reserved, unused
//  C_S_AXI_ADDR_WIDTH    12            AXI-Lite address width; reserved, unused
//  C_BASEADDR            32'h80000000  AXI-Lite base address; reserved, unused
//  C_S_AXIS_DATA_WIDTH   512           stream data width (in and out)
//  C_S_AXIS_TUSER_WIDTH  128           stream tuser width (in and out)
//  C_M_AXIS_DATA_WIDTH   256           reserved, unused; m_axis width = C_S_AXIS_DATA_WIDTH
//  PHV_ADDR_WIDTH        4             reserved, unused
// PORTS
//  clk            in   1      stream clock; single clock domain
//  aresetn        in   1      asynchronous, active-low reset
//  s_axis_tdata   in   DW     input data, DW = C_S_AXIS_DATA_WIDTH
//  s_axis_tkeep   in   DW/8   input byte enables
//  s_axis_tuser   in   UW     input sideband, UW = C_S_AXIS_TUSER_WIDTH; meaningful on first beat only
//  s_axis_tvalid  in   1      input beat valid
//  s_axis_tready  out  1      block can accept a beat
//  s_axis_tlast   in   1      last beat of packet
//  m_axis_tdata   out  DW     output data
//  m_axis_tkeep   out  DW/8   output byte enables
//  m_axis_tuser   out  UW     first-beat tuser, repeated on every beat of the packet
//  m_axis_tvalid  out  1      output beat valid
//  m_axis_tready  in   1      downstream can accept
//  m_axis_tlast   out  1      last beat of packet
// BEHAVIOUR
//  - Reset (aresetn=0, async assert, sync deassert): m_axis_tvalid=0, s_axis_tready=0,
//    m_axis_tdata/tkeep/tuser/tlast=0, skid buffer empty, in_pkt=0.
//    s_axis_tready rises on the 1st clk edge after deassertion.
//  - Beat transfer occurs when valid&&ready on a clk edge, on either side.
//  - Output register plus one-entry skid register.
//    When the output register is empty or draining, an input beat loads it directly
//    (latency 1 clk). If the output register is stalled (m_tvalid && !m_tready), the
//    input beat goes to the skid register.
//  - s_axis_tready is registered: it is 1 iff the skid register is empty.
//    The skid register refills the output register on the next output handshake.
//  - Full throughput: continuous tvalid with m_axis_tready=1 yields one beat per clk, no bubbles.
//  - No beat is lost or duplicated; order is preserved. tdata/tkeep/tlast are passed bit-exact.
//  - in_pkt flag: set on an accepted beat with tlast=0, cleared on an accepted beat with tlast=1.
//    - Accepted beat with in_pkt=0 (first beat): latch tuser_hold <= s_axis_tuser; the beat carries s_axis_tuser.
//    - Accepted beat with in_pkt=1: the beat carries tuser_hold.
//    - A single-beat packet (tlast on the first beat) never sets in_pkt.
//  - tkeep is not interpreted. A beat with tkeep=0 is forwarded as-is.
//  - Output data/sideband are stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI rule).
//  - Reset mid-packet discards all buffered beats. The next accepted beat is treated as a first beat.
//  - m_axis_tready may toggle arbitrarily. tvalid is never withdrawn by this block once asserted.
// STRUCTURE
//  - Shared package: localparams for the stream beat struct {tdata, tkeep, tuser, tlast}
//    and its packed width DW+DW/8+UW+1.
//  - One natural sub-module: axis_skid_slice (generic packed-beat register slice, width param).
//  - The top level adds in_pkt and tuser_hold around it.
// TESTING
//  1. Reset: hold aresetn=0 with tvalid=1 -> m_axis_tvalid=0, s_axis_tready=0;
//     after release, s_axis_tready=1 within 1 clk.
//  2. Single-beat packet (tdata=512'hA5.., tkeep=64'hFFFF_FFFF_FFFF_FFFF, tuser=128'h1234,
//     tlast=1), m_tready=1 -> identical beat on m_axis exactly 1 clk later.
//  3. 4-beat packet, tuser=128'hBEEF on beat 0 and 0 on beats 1-3 -> all 4 output beats
//     have tuser=128'hBEEF; tlast only on beat 3; back-to-back with no gaps.
//  4. Backpressure: m_tready=0 for 5 clks during a 6-beat stream -> s_axis_tready drops
//     after the skid register fills; all 6 beats emerge in order, none lost or duplicated.
//  5. Random tvalid/m_tready (10k beats, random lengths 1-16) -> scoreboard matches
//     every beat and tuser rule; AXI stability assertions hold.
//  6. aresetn pulsed mid-packet -> outputs clear immediately; the next packet's first-beat tuser is latched correctly.

Source files
------------

// File: rtl/rmt_demo_pkg.sv
// Shared definitions for the RMT extract front-end: default stream widths and the
// packed beat layout {tdata, tkeep, tuser, tlast} carried through the register slice.
package rmt_demo_pkg;

  localparam int DEF_DATA_W  = 512;
  localparam int DEF_TUSER_W = 128;

  // Packed beat width: tdata + tkeep (one bit per byte) + tuser + tlast
  function automatic int beat_width(input int dw, input int uw);
    return dw + dw / 8 + uw + 1;
  endfunction

endpackage

// File: rtl/rmt_demo_axis_skid_slice.sv
// Generic valid/ready register slice: one output register plus one skid register,
// registered upstream ready, one beat per clock when downstream keeps up.
module axis_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             s_ready_q, s_ready_d;
  logic             in_fire;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    in_fire      = s_valid && s_ready_q;

    // Ready is only high while the skid is empty, so in_fire never collides with a skid refill
    if (!out_valid_q || m_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = s_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end

    s_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      s_ready_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      s_ready_q    <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

endmodule

// File: rtl/rmt_demo.sv
// AXI4-Stream register slice at the head of the RMT extract pipeline; the first-beat
// tuser of each packet is held and replayed on every beat of that packet.
module rmt_demo
  import rmt_demo_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH   = 32,
  parameter int          C_S_AXI_ADDR_WIDTH   = 12,
  parameter logic [31:0] C_BASEADDR           = 32'h80000000,
  parameter int          C_S_AXIS_DATA_WIDTH  = DEF_DATA_W,
  parameter int          C_S_AXIS_TUSER_WIDTH = DEF_TUSER_W,
  parameter int          C_M_AXIS_DATA_WIDTH  = 256,
  parameter int          PHV_ADDR_WIDTH       = 4
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int BW = beat_width(DW, UW);

  // The AXI-Lite and PHV parameters are reserved; this never elaborates
  if (C_S_AXI_DATA_WIDTH < 0 || C_S_AXI_ADDR_WIDTH < 0 || C_M_AXIS_DATA_WIDTH < 0 ||
      PHV_ADDR_WIDTH < 0 || C_BASEADDR[1:0] != 2'b00) begin : g_reserved_check
  end

  logic          in_pkt_q, in_pkt_d;
  logic [UW-1:0] tuser_hold_q, tuser_hold_d;
  logic [UW-1:0] beat_tuser;
  logic          in_fire;
  logic [BW-1:0] s_beat;
  logic [BW-1:0] m_beat;

  always_comb begin
    in_fire      = s_axis_tvalid && s_axis_tready;
    in_pkt_d     = in_pkt_q;
    tuser_hold_d = tuser_hold_q;
    beat_tuser   = in_pkt_q ? tuser_hold_q : s_axis_tuser;

    if (in_fire) begin
      in_pkt_d = !s_axis_tlast;
      if (!in_pkt_q) begin
        tuser_hold_d = s_axis_tuser;
      end
    end

    s_beat = {s_axis_tdata, s_axis_tkeep, beat_tuser, s_axis_tlast};
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      in_pkt_q     <= 1'b0;
      tuser_hold_q <= '0;
    end else begin
      in_pkt_q     <= in_pkt_d;
      tuser_hold_q <= tuser_hold_d;
    end
  end

  axis_skid_slice #(
    .WIDTH(BW)
  ) u_slice (
    .clk    (clk),
    .rst_n  (aresetn),
    .s_data (s_beat),
    .s_valid(s_axis_tvalid),
    .s_ready(s_axis_tready),
    .m_data (m_beat),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = m_beat;

endmodule

// File: tb/tb_rmt_demo.sv
// Self-checking bench for rmt_demo: directed scenarios plus a randomized packet stream,
// with expected beats derived from what was offered and each packet's first-beat tuser.
module tb_rmt_demo;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 128;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_pct = 100;
  logic [UW-1:0] cur_pkt_tuser = '0;

  // Expected beats: every accepted input beat, with tuser replaced by its packet's first-beat tuser
  beat_t exp_q[$];
  beat_t got_q[$];
  int    got_cyc[$];

  rmt_demo dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tuser (s_tuser),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tuser (m_tuser),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Downstream ready: random with probability ready_pct, updated just after each edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      m_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // Record both handshakes at the falling edge, where all signals are settled
  always @(negedge clk) begin
    beat_t b;
    if (aresetn) begin
      if (s_tvalid && s_tready) begin
        b = {s_tdata, s_tkeep, cur_pkt_tuser, s_tlast};
        exp_q.push_back(b);
      end
      if (m_tvalid && m_tready) begin
        b = {m_tdata, m_tkeep, m_tuser, m_tlast};
        got_q.push_back(b);
        got_cyc.push_back(cyc);
      end
    end
  end

  // A stalled output beat must stay valid and unchanged until it is taken
  beat_t prev_beat;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || {m_tdata, m_tkeep, m_tuser, m_tlast} !== prev_beat) begin
          errors++;
          $display("[TB] FAIL axi_stable at cycle %0d: valid=%b tuser=%h, required valid=1 tuser=%h",
                   cyc, m_tvalid, m_tuser, prev_beat.u);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tdata, m_tkeep, m_tuser, m_tlast};
    end
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [UW-1:0] rand_tuser();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [KW-1:0] rand_keep();
    if ($urandom_range(9) == 0) return '0;
    return {$urandom, $urandom};
  endfunction

  // Offers one packet; must be called just after a rising edge
  task automatic send_pkt(input int len, input logic [UW-1:0] tu, input int valid_pct,
                          input bit rand_rest);
    bit accepted;
    int waited;
    for (int b = 0; b < len; b++) begin
      while (valid_pct < 100 && $urandom_range(99) >= valid_pct) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      cur_pkt_tuser = tu;
      s_tdata  = rand_data();
      s_tkeep  = rand_keep();
      s_tuser  = (b == 0) ? tu : (rand_rest ? rand_tuser() : '0);
      s_tlast  = (b == len - 1);
      s_tvalid = 1'b1;
      accepted = 1'b0;
      waited   = 0;
      while (!accepted) begin
        @(negedge clk);
        accepted = s_tready;
        @(posedge clk);
        #1;
        waited++;
        if (!accepted && waited > 500) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: beat %0d not accepted after %0d cycles, required within 500",
                   b, waited);
          s_tvalid = 1'b0;
          return;
        end
      end
    end
    s_tvalid = 1'b0;
  endtask

  // Lets the DUT empty out; ok=0 if outputs never caught up with accepted inputs
  task automatic drain(output bit ok);
    ready_pct = 100;
    s_tvalid  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (got_q.size() == exp_q.size() && !m_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = '1;
    s_tkeep  = '1;
    s_tuser  = '1;
    s_tlast  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_m_tvalid: got %b want 0", m_tvalid);
    end
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_s_tready: got %b want 0", s_tready);
    end
    checks++;
    if ({m_tdata, m_tkeep, m_tuser, m_tlast} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: tuser=%h tlast=%b, required all zero", m_tuser, m_tlast);
    end
    aresetn = 1'b1;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_ready_early: got %b want 0 before first edge", s_tready);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release_ready: got %b want 1 after first edge", s_tready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_beat();
    logic [DW-1:0] a5;
    bit ok;
    a5 = {64{8'hA5}};
    ready_pct = 100;
    cur_pkt_tuser = 128'h1234;
    s_tdata  = a5;
    s_tkeep  = 64'hFFFF_FFFF_FFFF_FFFF;
    s_tuser  = 128'h1234;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_latency_early: m_tvalid=%b want 0 before capture edge", m_tvalid);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== a5 || m_tkeep !== 64'hFFFF_FFFF_FFFF_FFFF ||
        m_tuser !== 128'h1234 || m_tlast !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_beat: valid=%b tdata[31:0]=%h tuser=%h tlast=%b, required 1 a5a5a5a5 1234 1",
               m_tvalid, m_tdata[31:0], m_tuser, m_tlast);
    end
    drain(ok);
    checks++;
    if (!ok || got_q.size() != 1 || exp_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d beats, required 1 (accepted %0d)", got_q.size(), exp_q.size());
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_multi_beat();
    bit ok;
    ready_pct = 100;
    send_pkt(4, 128'hBEEF, 100, 1'b0);
    drain(ok);
    checks++;
    if (!ok || got_q.size() != 4 || exp_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL multi_count: got %0d beats, required 4 (accepted %0d)", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_q[i].u !== 128'hBEEF || got_q[i].l !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL multi_beat[%0d]: tuser=%h tlast=%b d=%h, required tuser=beef tlast=%b d=%h",
                 i, got_q[i].u, got_q[i].l, got_q[i].d[63:0], (i == 3), exp_q[i].d[63:0]);
      end
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      checks++;
      if (got_cyc[i] != got_cyc[i-1] + 1) begin
        errors++;
        $display("[TB] FAIL multi_gap[%0d]: output at cycle %0d, required %0d", i, got_cyc[i], got_cyc[i-1] + 1);
      end
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    bit saw_drop;
    saw_drop  = 1'b0;
    ready_pct = 100;
    fork
      send_pkt(6, 128'hB0B0, 100, 1'b1);
      begin
        @(posedge clk);
        #1;
        ready_pct = 0;
        repeat (5) begin
          @(negedge clk);
          if (!s_tready) saw_drop = 1'b1;
          @(posedge clk);
          #1;
        end
        ready_pct = 100;
      end
    join
    drain(ok);
    checks++;
    if (saw_drop !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ready_drop: s_tready drop seen=%b, required 1", saw_drop);
    end
    checks++;
    if (!ok || got_q.size() != 6 || exp_q.size() != 6) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d beats, required 6 (accepted %0d)", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL bp_beat[%0d]: d=%h tuser=%h tlast=%b, required d=%h tuser=%h tlast=%b",
                 i, got_q[i].d[63:0], got_q[i].u, got_q[i].l, exp_q[i].d[63:0], exp_q[i].u, exp_q[i].l);
      end
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_random();
    bit ok;
    int total;
    int len;
    total = 0;
    ready_pct = 70;
    while (total < 10000) begin
      len = $urandom_range(1, 16);
      send_pkt(len, rand_tuser(), 70, 1'b1);
      total += len;
    end
    drain(ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size() || exp_q.size() != total) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d beats, required %0d (accepted %0d)",
               got_q.size(), total, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL rand_beat[%0d]: d=%h k=%h tuser=%h tlast=%b, required d=%h k=%h tuser=%h tlast=%b",
                 i, got_q[i].d[63:0], got_q[i].k, got_q[i].u, got_q[i].l,
                 exp_q[i].d[63:0], exp_q[i].k, exp_q[i].u, exp_q[i].l);
      end
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    logic [UW-1:0] tu_b;
    ready_pct = 0;
    cur_pkt_tuser = 128'hAAAA;
    for (int b = 0; b < 3; b++) begin
      s_tdata  = rand_data();
      s_tkeep  = '1;
      s_tuser  = (b == 0) ? 128'hAAAA : rand_tuser();
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      @(posedge clk);
      #1;
    end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || {m_tdata, m_tkeep, m_tuser, m_tlast} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: m_tvalid=%b s_tready=%b tuser=%h, required 0 0 0",
               m_tvalid, s_tready, m_tuser);
    end
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    @(posedge clk);
    #1;
    ready_pct = 100;
    tu_b = 128'hC0FFEE;
    send_pkt(3, tu_b, 100, 1'b1);
    drain(ok);
    checks++;
    if (!ok || got_q.size() != 3 || exp_q.size() != 3) begin
      errors++;
      $display("[TB] FAIL midreset_count: got %0d beats, required 3 (accepted %0d)", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_q[i].u !== tu_b) begin
        errors++;
        $display("[TB] FAIL midreset_beat[%0d]: tuser=%h d=%h, required tuser=%h d=%h",
                 i, got_q[i].u, got_q[i].d[63:0], tu_b, exp_q[i].d[63:0]);
      end
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if anything above stops making progress
  initial begin
    #900000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
